// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//
// Row/pixel scan sequencer for the display adapter. For every row it reads one
// 16-bit word from the synchronous frame buffer into a line buffer. It then
// streams that row's pixels LSB-first, one bit per Ready handshake, to the
// display output stage. The position within the row comes from an external
// 4-bit pixel counter, which this block steers through ResetPx and IncPx.
// After the last row it pulses FrameDone and returns to IDLE.
//
// Optional feature macro: SCAN_BLANK_EN
//   When defined, a BLANK state of BLANK_CYCLES cycles is inserted between the
//   last pixel of a row and LINE_END.
//
// Parameters:
//   PX_PER_ROW   pixels per row (2..16)
//   ROWS         rows per frame (2..16)
//   BLANK_CYCLES blanking cycles per row (1..15), used with SCAN_BLANK_EN only
//
// Ports:
//   clock      in   system clock, rising edge
//   ResetN     in   asynchronous active-low reset
//   Start      in   begin a frame (sampled in IDLE only)
//   PxOut      in   [3:0]  current pixel index from the pixel counter
//   RowData    in   [15:0] frame-buffer read data, valid the cycle after RdEn
//   Ready      in   display stage accepts a pixel this cycle
//   ResetPx    out  clear the pixel counter at the next edge
//   IncPx      out  increment the pixel counter at the next edge
//   RdEn       out  frame-buffer read strobe
//   RowAddr    out  [3:0]  row being fetched or displayed
//   PixelData  out  current pixel, LineBuf[PxOut]
//   PixelValid out  PixelData is offered
//   Busy       out  high in every state except IDLE
//   FrameDone  out  one-cycle pulse at the end of the last row
// -----------------------------------------------------------------------------
module display_scan_controller #(
  parameter int PX_PER_ROW   = 16,
  parameter int ROWS         = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clock,
  input  logic        ResetN,
  input  logic        Start,
  input  logic [3:0]  PxOut,
  input  logic [15:0] RowData,
  input  logic        Ready,
  output logic        ResetPx,
  output logic        IncPx,
  output logic        RdEn,
  output logic [3:0]  RowAddr,
  output logic        PixelData,
  output logic        PixelValid,
  output logic        Busy,
  output logic        FrameDone
);

  localparam logic [3:0] LAST_PX  = 4'(PX_PER_ROW - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  // Elaboration-time guard on the parameter ranges the 4-bit counters support.
  if (PX_PER_ROW < 2 || PX_PER_ROW > 16) begin : g_bad_px_per_row
    $error("display_scan_controller: PX_PER_ROW must be in 2..16");
  end
  if (ROWS < 2 || ROWS > 16) begin : g_bad_rows
    $error("display_scan_controller: ROWS must be in 2..16");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 15) begin : g_bad_blank_cycles
    $error("display_scan_controller: BLANK_CYCLES must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    BLANK,
    LINE_END
  } state_t;

  state_t      state;
  logic [15:0] line_buf;
  logic [3:0]  row_addr;
  logic        last_px;

`ifdef SCAN_BLANK_EN
  localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);
  logic [3:0] blank_cnt;
`endif

  // An out-of-range counter value is treated as the last pixel, so a miswired
  // counter can never trap the scan inside a row.
  assign last_px = (PxOut >= LAST_PX);

  // ---------------------------------------------------------------------------
  // State, row address and line buffer
  // ---------------------------------------------------------------------------
  // NOTE: every register written here uses <=, so all of them update together
  // at the edge. Reading a register in this block always returns its value
  // from before the edge.
  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      row_addr <= '0;
      // NOTE: line_buf is a plain 16-bit register rather than a RAM. It is
      // cleared on reset so that nothing from an aborted frame survives.
      line_buf <= '0;
`ifdef SCAN_BLANK_EN
      blank_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) state <= FETCH;
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          line_buf <= RowData;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (Ready && last_px) begin
`ifdef SCAN_BLANK_EN
            blank_cnt <= '0;
            state     <= BLANK;
`else
            state <= LINE_END;
`endif
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (blank_cnt == BLANK_LAST) state <= LINE_END;
          else                         blank_cnt <= blank_cnt + 4'd1;
        end
`endif
        LINE_END: begin
          // The row address is bounded explicitly and never relies on wrapping.
          if (row_addr == LAST_ROW) begin
            row_addr <= '0;
            state    <= IDLE;
          end else begin
            row_addr <= row_addr + 4'd1;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the state (plus Ready and PxOut in SHIFT)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case. Any path that does
    // not assign an output therefore leaves it 0 and cannot infer a latch.
    ResetPx    = 1'b0;
    IncPx      = 1'b0;
    RdEn       = 1'b0;
    PixelValid = 1'b0;
    PixelData  = 1'b0;
    FrameDone  = 1'b0;
    Busy       = (state != IDLE);
    case (state)
      FETCH: begin
        RdEn    = 1'b1;
        ResetPx = 1'b1;
      end
      SHIFT: begin
        PixelValid = 1'b1;
        PixelData  = line_buf[PxOut];
        // Ready=0 holds the counter, so PixelData stays stable across a stall.
        IncPx      = Ready && !last_px;
        ResetPx    = Ready && last_px;
      end
      LINE_END: begin
        FrameDone = (row_addr == LAST_ROW);
      end
      default: ;
    endcase
  end

  assign RowAddr = row_addr;

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

  localparam int PX     = 16;
  localparam int NROWS  = 16;
`ifdef SCAN_BLANK_EN
  localparam int BLANK_N = 4;
`else
  localparam int BLANK_N = 0;
`endif
  localparam int BUDGET = 4000;

  logic        clock   = 1'b0;
  logic        ResetN  = 1'b0;
  logic        Start   = 1'b0;
  logic [3:0]  PxOut   = '0;
  logic [15:0] RowData = '0;
  logic        Ready   = 1'b0;
  logic        ResetPx;
  logic        IncPx;
  logic        RdEn;
  logic [3:0]  RowAddr;
  logic        PixelData;
  logic        PixelValid;
  logic        Busy;
  logic        FrameDone;

  int errors = 0;
  int checks = 0;

  // Frame buffer contents and the behavioural pixel counter value.
  logic [15:0] mem [NROWS];
  int          px = 0;

  display_scan_controller #(
    .PX_PER_ROW  (PX),
    .ROWS        (NROWS),
    .BLANK_CYCLES(4)
  ) dut (
    .clock     (clock),
    .ResetN    (ResetN),
    .Start     (Start),
    .PxOut     (PxOut),
    .RowData   (RowData),
    .Ready     (Ready),
    .ResetPx   (ResetPx),
    .IncPx     (IncPx),
    .RdEn      (RdEn),
    .RowAddr   (RowAddr),
    .PixelData (PixelData),
    .PixelValid(PixelValid),
    .Busy      (Busy),
    .FrameDone (FrameDone)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {20'd0, ResetPx, IncPx, RdEn, RowAddr, PixelData, PixelValid, Busy, FrameDone}, 32'd0);
  endtask

  // One clock edge. The pixel counter and the frame buffer respond to the
  // strobes that were present before the edge. New input values appear 1 ns
  // after the edge.
  task automatic cycle();
    logic       rp, ip, rd;
    logic [3:0] ra;
    rp = ResetPx;
    ip = IncPx;
    rd = RdEn;
    ra = RowAddr;
    @(posedge clock);
    #1;
    if (rp)      px = 0;
    else if (ip) px = (px + 1) % 16;
    PxOut = 4'(px);
    if (rd) RowData = mem[ra];
  endtask

  // Run one complete frame. mode: 0 = Ready always 1, 1 = random Ready,
  // 2 = Ready repeating 1,0,0,1. noise drives random Start during Busy and
  // forces Start high in the FrameDone cycle.
  task automatic run_frame(input string name, input int mode, input bit noise);
    logic exp_q [$];
    bit   pat [4];
    int   row, stalls, k, exp_len;
    bit   finished, prev_stall;
    logic prev_data;
    pat        = '{1'b1, 1'b0, 1'b0, 1'b1};
    row        = 0;
    stalls     = 0;
    k          = 0;
    finished   = 0;
    prev_stall = 0;
    prev_data  = 1'b0;
    exp_len    = NROWS * (PX + 3 + BLANK_N);
    for (int r = 0; r < NROWS; r++)
      for (int b = 0; b < PX; b++)
        exp_q.push_back(mem[r][b]);

    Start = 1'b1;
    Ready = 1'b1;
    #1;
    check($sformatf("%s/idle_before", name), Busy, 0);
    cycle();
    for (int cyc = 1; cyc <= BUDGET && !finished; cyc++) begin
      case (mode)
        0:       Ready = 1'b1;
        1:       Ready = ($urandom_range(0, 3) != 0);
        default: Ready = pat[k % 4];
      endcase
      k++;
      Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check($sformatf("%s/busy", name), Busy, 1);
      check($sformatf("%s/inc_rst_excl", name), IncPx & ResetPx, 0);
      if (RdEn) begin
        check($sformatf("%s/rd_row", name), RowAddr, row);
        check($sformatf("%s/rd_resetpx", name), ResetPx, 1);
        row++;
      end
      if (PixelValid) begin
        if (prev_stall) check($sformatf("%s/stall_hold", name), PixelData, prev_data);
        if (Ready) begin
          if (exp_q.size() != 0)
            check($sformatf("%s/pixel r%0d p%0d", name, RowAddr, PxOut), PixelData, exp_q.pop_front());
          else
            check($sformatf("%s/extra_pixel", name), PixelValid & Ready, 0);
          check($sformatf("%s/inc", name), IncPx, (PxOut != 4'(PX - 1)));
          check($sformatf("%s/rst_last", name), ResetPx, (PxOut == 4'(PX - 1)));
        end else begin
          stalls++;
          check($sformatf("%s/stall_quiet", name), {IncPx, ResetPx}, 0);
        end
        prev_stall = !Ready;
        prev_data  = PixelData;
      end else begin
        prev_stall = 0;
        check($sformatf("%s/no_inc", name), IncPx, 0);
      end
      if (FrameDone) begin
        check($sformatf("%s/frame_len", name), cyc, exp_len + stalls);
        check($sformatf("%s/done_row", name), RowAddr, NROWS - 1);
        finished = 1;
        if (noise) Start = 1'b1;
      end
      cycle();
    end
    check($sformatf("%s/frame_done_seen", name), finished, 1);
    check($sformatf("%s/pixels_left", name), exp_q.size(), 0);
    check($sformatf("%s/rows_fetched", name), row, NROWS);
    // First IDLE cycle: Busy has fallen and Start seen in FrameDone is ignored.
    Start = 1'b0;
    #1;
    check($sformatf("%s/busy_after", name), Busy, 0);
    check($sformatf("%s/done_once", name), FrameDone, 0);
    cycle();
    #1;
    check($sformatf("%s/stay_idle", name), {Busy, RdEn}, 0);
    cycle();
  endtask

  initial begin
    bit hit;

    // Reset state.
    #2;
    check_zero("reset_state");
    #10 ResetN = 1'b1;
    @(posedge clock);
    #1;
    #1;
    check_zero("idle_no_start");
    cycle();

    // Frame 1: Ready always 1, RowData = A5A5 + row.
    for (int r = 0; r < NROWS; r++) mem[r] = 16'hA5A5 + 16'(r);
    run_frame("frame_a5", 0, 1'b0);

    // Frame 2: random data, random Ready, Start noise while Busy.
    for (int r = 0; r < NROWS; r++) mem[r] = 16'($urandom);
    run_frame("frame_rand", 1, 1'b1);

    // Reset in the middle of row 5 at pixel 7.
    Start = 1'b1;
    Ready = 1'b1;
    #1;
    cycle();
    Start = 1'b0;
    hit   = 0;
    for (int c = 0; c < BUDGET && !hit; c++) begin
      #1;
      if (PixelValid && RowAddr == 4'd5 && PxOut == 4'd7) hit = 1;
      else cycle();
    end
    check("reset_target_reached", hit, 1);
    #1 ResetN = 1'b0;
    #1;
    check_zero("reset_mid_row");
    repeat (2) @(posedge clock);
    #3 ResetN = 1'b1;
    cycle();
    #1;
    check("no_resume_without_start", {Busy, RdEn}, 0);
    cycle();
    #1;
    check("still_idle_after_reset", Busy, 0);
    cycle();

    // Frame 3: backpressure pattern 1,0,0,1 after the reset; the frame restarts at row 0.
    for (int r = 0; r < NROWS; r++) mem[r] = 16'($urandom);
    run_frame("frame_bp", 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
